// File: rtl/prio_req_sequencer.sv
// prio_req_sequencer: synchronises and edge-detects 16 request lines, holds them pending and
// grants one index at a time from an external priority encoder. Optional feature: PRIO_SEQ_MASK_EN.
module prio_req_sequencer #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] NONE_CODE   = 8'hF0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req_in,
`ifdef PRIO_SEQ_MASK_EN
    input  logic [15:0] req_mask,
`endif
    output logic [15:0] pend_out,
    input  logic [7:0]  enc_idx_in,
    output logic        gnt_valid,
    output logic [3:0]  gnt_idx,
    input  logic        gnt_ready,
    output logic [7:0]  drop_cnt,
    output logic        enc_err
);

    typedef enum logic [1:0] {IDLE, LOOKUP, OFFER} state_e;

    state_e                       state_q;
    logic [SYNC_STAGES-1:0][15:0] sync_q;
    logic [15:0]                  sync_last;
    logic [15:0]                  dly_q;
    logic [15:0]                  pend_q;
    logic [15:0]                  pend_d;
    logic [15:0]                  evt;
    logic [15:0]                  clr;
    logic                         accept;
    logic                         drop_hit;
    logic [7:0]                   drop_cnt_q;
    logic                         gnt_valid_q;
    logic [3:0]                   gnt_idx_q;
    logic                         enc_err_q;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign evt       = sync_last & ~dly_q;
    assign accept    = gnt_valid_q & gnt_ready;

    // NOTE: clr gets a default before the indexed write, otherwise a latch is inferred.
    always_comb begin
        clr = '0;
        if (accept) clr[gnt_idx_q] = 1'b1;
    end

    // A new event on the bit being granted keeps it pending (set wins over clear).
    assign pend_d   = (pend_q & ~clr) | evt;
    assign drop_hit = |(evt & pend_q & ~clr);

    // NOTE: every flop here, including the synchroniser, is async-reset; state must be
    // assigned with <= so all flops see the pre-edge values of their neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            dly_q      <= '0;
            pend_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
            dly_q  <= sync_last;
            pend_q <= pend_d;
            if (drop_hit && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

`ifdef PRIO_SEQ_MASK_EN
    logic [15:0] pend_vis_q;

    // Masked bits keep latching internally; only their visibility to the encoder is gated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_vis_q <= '0;
        else        pend_vis_q <= pend_d & ~req_mask;
    end

    assign pend_out = pend_vis_q;
`else
    assign pend_out = pend_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            enc_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|pend_out) state_q <= LOOKUP;
                end
                LOOKUP: begin
                    if (enc_idx_in <= 8'd15) begin
                        gnt_idx_q   <= enc_idx_in[3:0];
                        gnt_valid_q <= 1'b1;
                        state_q     <= OFFER;
                    end else begin
                        if (enc_idx_in != NONE_CODE) enc_err_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                OFFER: begin
                    // The grant is held until taken; newer events wait for the next lookup.
                    if (gnt_ready) begin
                        gnt_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    gnt_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;
    assign drop_cnt  = drop_cnt_q;
    assign enc_err   = enc_err_q;

endmodule

// File: doc/prio_req_sequencer.md
Name: prio_req_sequencer

Overview:
- Request-capture and grant stage wrapped around the 16-bit highest-index priority encoder.
- Synchronises 16 asynchronous request lines, edge-detects them and holds a pending vector; that vector is the encoder's 16-bit input.
- Consumes the encoder's 8-bit index result and issues one grant at a time over a valid/ready handshake, clearing the granted pending bit on acceptance.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on req_in (legal range 2..4).
- NONE_CODE, 8'hF0, encoder result meaning "no bit set".

Ports:
- clk  input  1  clock; all flops rise-edge.
- rst_n  input  1  asynchronous active-low reset.
- req_in  input  16  asynchronous request lines; rising edge = one event.
- pend_out  output  16  registered pending vector; bit 15 = highest priority; drives the encoder.
- enc_idx_in  input  8  combinational encoder result for pend_out (0..15 or NONE_CODE).
- gnt_valid  output  1  grant offered.
- gnt_idx  output  4  index being granted; stable while gnt_valid=1.
- gnt_ready  input  1  consumer accepts the grant when gnt_valid&gnt_ready.
- drop_cnt  output  8  saturating count of events lost on already-pending bits.
- enc_err  output  1  sticky: enc_idx_in was out of range when sampled.

Behaviour:
- Reset (async assert, sync release): synchroniser, delay flops, pending, FSM=IDLE, gnt_valid=0, gnt_idx=0, drop_cnt=0, enc_err=0.
- Synchroniser flops reset to 0. A line held high through reset release therefore produces exactly one event.
- Edge detect: evt[i] = sync_last[i] & ~dly[i]. dly is sampled from sync_last every cycle.
- Pending update per bit, each clock:
  - evt[i] sets pend[i].
  - Accepted grant on i clears pend[i].
  - Set and clear in the same cycle: set wins, so the bit stays pending as a new event.
- drop_cnt: +1 per cycle in which any evt[i] hits a bit already pending and not being cleared that cycle. Multiple simultaneous drops count as 1. Saturates at 255, no wrap.
- FSM states: IDLE, LOOKUP, OFFER.
  - IDLE: if |pend_out -> LOOKUP; else stay.
  - LOOKUP (one cycle; encoder is combinational on registered pend_out):
    - enc_idx_in <= 15 -> latch gnt_idx = enc_idx_in[3:0], go OFFER.
    - enc_idx_in == NONE_CODE -> IDLE.
    - Any other value -> set enc_err, go IDLE.
  - OFFER: gnt_valid=1 (registered; asserts the cycle OFFER is entered).
    - gnt_idx and gnt_valid are held until gnt_valid&gnt_ready.
    - On acceptance: clear pend[gnt_idx] (subject to set-wins), gnt_valid=0 next cycle, go IDLE.
    - New higher-priority events during OFFER do not preempt the current grant.
- Throughput: one grant per 3 cycles max (IDLE->LOOKUP->OFFER, with immediate ready).
- Latency, idle FSM, gnt_ready=1: req_in high before edge 1 -> gnt_valid high after edge SYNC_STAGES+3 (edge 5 at default).
- gnt_ready while gnt_valid=0 is ignored.
- A reset mid-OFFER drops the grant and all pending events; no acceptance is implied.

Optional Feature:
- Macro PRIO_SEQ_MASK_EN.
- Defined:
  - Adds input req_mask[15:0].
  - pend_out = pending & ~req_mask; masked bits still latch and still count drops.
  - Unmasking a pending bit makes it visible on the next cycle.
  - Masking a bit during OFFER does not withdraw the current grant.
- Undefined: no req_mask port; pend_out = pending.

Test Plan:
- Reset with req_in=0 -> pend_out=0, gnt_valid=0, drop_cnt=0, enc_err=0. Then pulse req_in[5] for 3 cycles with encoder model attached and gnt_ready=1 -> gnt_valid at edge 5 with gnt_idx=5, pend_out returns to 0.
- Set req_in[3] and req_in[12] in the same cycle, gnt_ready=1 -> grants in order 12 then 3, 3 cycles apart; pend_out 0x1008 -> 0x0008 -> 0x0000.
- Hold gnt_ready=0 in OFFER for idx 7; raise req_in[9] -> gnt_idx stays 7 until ready. Then grant 9 follows, not preempting 7.
- Re-pulse req_in[2] (low 3 cycles, high 3 cycles) 300 times while bit 2 is pending and gnt_ready=0 -> drop_cnt saturates at 255.
- Re-pulse req_in[4] such that its edge lands in the same cycle its grant is accepted -> pend_out[4] remains 1, a second grant for 4 follows, drop_cnt unchanged.
- Force enc_idx_in=8'h20 during LOOKUP -> enc_err=1 and sticky, FSM returns to IDLE, no grant. With PRIO_SEQ_MASK_EN defined, req_mask=0x0001, req_in[0] pulse -> pend_out=0, no grant; clear mask -> grant idx 0.
